// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory responder and its write buffer.
package dmem_pkg;

    localparam int DMEM_N     = 64;
    localparam int DMEM_WORDS = 64;
    localparam int WB_DEPTH   = 4;
    localparam int DMEM_AW    = $clog2(DMEM_WORDS);

    typedef struct packed {
        logic [DMEM_AW-1:0] idx;
        logic [DMEM_N-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/dmem_wbuf_responder_wbuf_fifo.sv
// Circular store buffer of {index, data} entries with a youngest-first index match search.
module wbuf_fifo
    import dmem_pkg::*;
#(
    parameter int N     = DMEM_N,
    parameter int AW    = DMEM_AW,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_idx,
    input  logic [N-1:0]  push_data,
    input  logic          pop,
    output logic [AW-1:0] head_idx,
    output logic [N-1:0]  head_data,
    output logic          full,
    output logic          empty,
    input  logic [AW-1:0] match_idx,
    output logic          hit,
    output logic [N-1:0]  hit_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [N-1:0]  data;
    } entry_t;

    entry_t        slot_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] slot_s;
    logic          match_s;

    // Next-state for pointers and occupancy; push and pop together leave count unchanged.
    always_comb begin
        head_d = pop  ? head_q + PW'(1) : head_q;
        tail_d = push ? tail_q + PW'(1) : tail_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state; reset discards all buffered stores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_q[tail_q] <= {push_idx, push_data};
        end
    end

    // Walk oldest to youngest so the last live match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        slot_s   = head_q;
        match_s  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_s   = head_q + PW'(i);
            match_s  = (CW'(i) < count_q) && (slot_q[slot_s].idx == match_idx);
            hit      = hit | match_s;
            hit_data = match_s ? slot_q[slot_s].data : hit_data;
        end
    end

    assign head_idx  = slot_q[head_q].idx;
    assign head_data = slot_q[head_q].data;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == CW'(0));

endmodule

// File: rtl/dmem_wbuf_responder.sv
// Zero-latency data-memory responder: posted stores drain from a write buffer in load-free
// cycles (or when the buffer is full), and loads forward from the buffer.
module dmem_wbuf_responder
    import dmem_pkg::*;
#(
    parameter int N         = DMEM_N,
    parameter int DEPTH     = WB_DEPTH,
    parameter int MEM_WORDS = DMEM_WORDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    output logic [N-1:0] DM_readData,
    output logic         wb_empty,
    output logic         wb_full
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [N-1:0]  mem_q [MEM_WORDS];
    logic [AW-1:0] idx_s;
    logic [AW-1:0] head_idx_s;
    logic [N-1:0]  head_data_s;
    logic [N-1:0]  hit_data_s;
    logic [N-1:0]  read_data_s;
    logic          hit_s;
    logic          full_s;
    logic          empty_s;
    logic          drain_s;
    logic          unused_addr_s;

    assign idx_s         = DM_addr[AW+2:3];
    assign unused_addr_s = ^{DM_addr[N-1:AW+3], DM_addr[2:0]};
    assign drain_s       = !empty_s && (!DM_readEnable || full_s);

    wbuf_fifo #(
        .N     (N),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (DM_writeEnable),
        .push_idx  (idx_s),
        .push_data (DM_writeData),
        .pop       (drain_s),
        .head_idx  (head_idx_s),
        .head_data (head_data_s),
        .full      (full_s),
        .empty     (empty_s),
        .match_idx (idx_s),
        .hit       (hit_s),
        .hit_data  (hit_data_s)
    );

    // Drain the head entry into the array; an edge under reset writes nothing.
    always_ff @(posedge clk) begin
        if (drain_s && !reset) begin
            mem_q[head_idx_s] <= head_data_s;
        end
    end

    // Load path: buffer forwarding overrides the array, idle port reads as zero.
    always_comb begin
        if (!DM_readEnable) begin
            read_data_s = '0;
        end else if (hit_s) begin
            read_data_s = hit_data_s;
        end else begin
            read_data_s = mem_q[idx_s];
        end
    end

    assign DM_readData = read_data_s;
    assign wb_empty    = empty_s;
    assign wb_full     = full_s;

endmodule
